maquina_de_cafe_multi: RTL and testbench

//  Parametrised coffee/tea vending controller with N products. Accumulates

---
 rtl/maquina_de_cafe_multi.sv | 171 +++++++++++++++++
 tb/tb_maquina_de_cafe_multi.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/maquina_de_cafe_multi.sv
// rtl/maquina_de_cafe_multi.sv - coffee/tea vending controller: credit, stock/water checks, timed serve, change.
module maquina_de_cafe_multi #(
  parameter int N_PROD      = 2,
  parameter int CREDIT_W    = 6,
  parameter int COIN_HI_VAL = 10,
  parameter int COIN_LO_VAL = 5,
  parameter int MAX_CREDIT  = 30,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {6'd5, 6'd10},
  parameter int SERVE_CYC   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_hi,
  input  logic                coin_lo,
  input  logic                ha,
  input  logic [N_PROD-1:0]   stock,
  input  logic [N_PROD-1:0]   sel,
  input  logic                cancel,
  output logic [N_PROD-1:0]   serve,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic [2:0]          status
);

  localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
  localparam int SUM_W = CREDIT_W + 2;
  localparam int CNT_W = (SERVE_CYC > 1) ? $clog2(SERVE_CYC) : 1;

  localparam logic [SUM_W-1:0] HI_V  = SUM_W'(COIN_HI_VAL);
  localparam logic [SUM_W-1:0] LO_V  = SUM_W'(COIN_LO_VAL);
  localparam logic [SUM_W-1:0] MAX_V = SUM_W'(MAX_CREDIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SERVE_CYC - 1);

  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_CREDIT  = 3'b001;
  localparam logic [2:0] ST_SERVING = 3'b010;
  localparam logic [2:0] ST_CHANGE  = 3'b011;
  localparam logic [2:0] ST_NOWATER = 3'b100;
  localparam logic [2:0] ST_NOSTOCK = 3'b101;
  localparam logic [2:0] ST_NOFUNDS = 3'b110;
  localparam logic [2:0] ST_BADSEL  = 3'b111;

  typedef enum logic [1:0] {IDLE, CREDIT, SERVE, CHANGE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;

  logic                coin_any;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] credit_add;
  logic                sel_any;
  logic                sel_multi;
  logic [IDX_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] price;

  // Both coins in one cycle are summed and accepted or rejected as a whole.
  always_comb begin
    coin_val = '0;
    if (coin_hi) coin_val = coin_val + HI_V;
    if (coin_lo) coin_val = coin_val + LO_V;
    coin_any   = coin_hi | coin_lo;
    sum        = {2'b00, credit} + coin_val;
    coin_ok    = coin_any && (sum <= MAX_V);
    credit_add = coin_ok ? sum[CREDIT_W-1:0] : credit;
  end

  always_comb begin
    sel_any   = |sel;
    sel_multi = (sel & (sel - 1'b1)) != '0;
    sel_idx   = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
    price = PRICES[sel_idx*CREDIT_W +: CREDIT_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      serve        <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      credit       <= '0;
      coin_reject  <= 1'b0;
      status       <= ST_IDLE;
    end else begin
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_any) begin
            if (coin_ok) begin
              credit <= sum[CREDIT_W-1:0];
              state  <= CREDIT;
              status <= ST_CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end

        CREDIT: begin
          if (cancel) begin
            change_amt   <= credit;
            change_valid <= credit != '0;
            credit       <= '0;
            coin_reject  <= coin_any;
            state        <= IDLE;
            status       <= ST_IDLE;
          end else if (sel_any) begin
            coin_reject <= coin_any && !coin_ok;
            credit      <= credit_add;
            if (sel_multi) begin
              status <= ST_BADSEL;
            end else if (!ha) begin
              status <= ST_NOWATER;
            end else if (!stock[sel_idx]) begin
              status <= ST_NOSTOCK;
            end else if (credit < price) begin
              status <= ST_NOFUNDS;
            end else begin
              // credit >= price here, so the subtraction cannot underflow
              credit <= credit_add - price;
              serve  <= sel;
              cnt    <= '0;
              state  <= SERVE;
              status <= ST_SERVING;
            end
          end else if (coin_any) begin
            status <= ST_CREDIT;
            if (coin_ok) credit <= sum[CREDIT_W-1:0];
            else         coin_reject <= 1'b1;
          end
        end

        SERVE: begin
          coin_reject <= coin_any;
          if (cnt == LAST) begin
            serve  <= '0;
            state  <= CHANGE;
            status <= ST_CHANGE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CHANGE: begin
          coin_reject <= coin_any;
          if (credit != '0) begin
            change_valid <= 1'b1;
            change_amt   <= credit;
          end
          credit <= '0;
          state  <= IDLE;
          status <= ST_IDLE;
        end

        default: begin
          state  <= IDLE;
          status <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maquina_de_cafe_multi.sv
// tb/tb_maquina_de_cafe_multi.sv - scoreboard bench for maquina_de_cafe_multi.
module tb_maquina_de_cafe_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_hi = 1'b0;
  logic       coin_lo = 1'b0;
  logic       ha = 1'b1;
  logic [1:0] stock = 2'b11;
  logic [1:0] sel = 2'b00;
  logic       cancel = 1'b0;
  logic [1:0] serve;
  logic       change_valid;
  logic [5:0] change_amt;
  logic [5:0] credit;
  logic       coin_reject;
  logic [2:0] status;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int vec;
    int len;
  } serve_t;

  int     exp_change[$];
  serve_t exp_serve[$];

  maquina_de_cafe_multi dut (
    .clk(clk), .rst(rst), .coin_hi(coin_hi), .coin_lo(coin_lo), .ha(ha),
    .stock(stock), .sel(sel), .cancel(cancel), .serve(serve),
    .change_valid(change_valid), .change_amt(change_amt), .credit(credit),
    .coin_reject(coin_reject), .status(status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: pops expected change pulses and serve runs as the DUT produces them.
  int run_len = 0;
  int run_vec = 0;
  always @(negedge clk) begin
    if (!rst) begin
      run_len = 0;
    end else begin
      if (change_valid) begin
        if (exp_change.size() == 0) check("change_unexpected", int'(change_amt), -1);
        else check("change_amt_sb", int'(change_amt), exp_change.pop_front());
      end
      if (serve != 2'b00) begin
        if (run_len == 0) run_vec = int'(serve);
        else if (int'(serve) != run_vec) check("serve_stable", int'(serve), run_vec);
        run_len++;
      end else if (run_len > 0) begin
        if (exp_serve.size() == 0) begin
          check("serve_unexpected", run_vec, -1);
        end else begin
          serve_t e;
          e = exp_serve.pop_front();
          check("serve_vec_sb", run_vec, e.vec);
          check("serve_len_sb", run_len, e.len);
        end
        run_len = 0;
      end
    end
  end

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply pulses for one clock edge; returns 1 time unit after that edge.
  task automatic drive(input logic hi, input logic lo, input logic [1:0] s, input logic c);
    coin_hi = hi; coin_lo = lo; sel = s; cancel = c;
    cycle(1);
    coin_hi = 1'b0; coin_lo = 1'b0; sel = 2'b00; cancel = 1'b0;
  endtask

  task automatic push_serve(input int v);
    serve_t e;
    e.vec = v;
    e.len = 4;
    exp_serve.push_back(e);
  endtask

  initial begin
    cycle(2);
    check("rst_serve", int'(serve), 0);
    check("rst_change_valid", int'(change_valid), 0);
    check("rst_change_amt", int'(change_amt), 0);
    check("rst_credit", int'(credit), 0);
    check("rst_coin_reject", int'(coin_reject), 0);
    check("rst_status", int'(status), 0);
    rst = 1'b1;
    cycle(1);

    // exact payment for cafe
    drive(1, 0, 2'b00, 0);
    check("t2_credit", int'(credit), 10);
    check("t2_status", int'(status), 1);
    push_serve(1);
    drive(0, 0, 2'b01, 0);
    check("t2_serve", int'(serve), 1);
    check("t2_credit_after", int'(credit), 0);
    check("t2_status_serving", int'(status), 2);
    cycle(6);
    check("t2_status_idle", int'(status), 0);

    // te with change
    drive(1, 0, 2'b00, 0);
    push_serve(2);
    exp_change.push_back(5);
    drive(0, 0, 2'b10, 0);
    check("t3_credit", int'(credit), 5);
    cycle(6);
    check("t3_change_amt", int'(change_amt), 5);
    check("t3_credit_end", int'(credit), 0);

    // insufficient credit, then top up
    drive(0, 1, 2'b00, 0);
    drive(0, 0, 2'b01, 0);
    check("t4_status_nofunds", int'(status), 6);
    check("t4_credit", int'(credit), 5);
    drive(0, 1, 2'b00, 0);
    check("t4_credit_topup", int'(credit), 10);
    push_serve(1);
    drive(0, 0, 2'b01, 0);
    check("t4_serve", int'(serve), 1);
    cycle(6);
    check("t4_change_amt_held", int'(change_amt), 5);

    // ceiling and cancel
    repeat (3) drive(1, 0, 2'b00, 0);
    check("t5_credit_max", int'(credit), 30);
    drive(0, 1, 2'b00, 0);
    check("t5_coin_reject", int'(coin_reject), 1);
    check("t5_credit_held", int'(credit), 30);
    exp_change.push_back(30);
    drive(0, 0, 2'b00, 1);
    check("t5_change_valid", int'(change_valid), 1);
    check("t5_change_amt", int'(change_amt), 30);
    check("t5_credit_zero", int'(credit), 0);
    check("t5_status", int'(status), 0);

    // both coins in one cycle
    drive(1, 1, 2'b00, 0);
    check("both_coins_credit", int'(credit), 15);
    exp_change.push_back(15);
    drive(0, 0, 2'b00, 1);
    check("both_coins_change", int'(change_amt), 15);

    // error codes and reset mid-serve
    drive(1, 0, 2'b00, 0);
    ha = 1'b0;
    drive(0, 0, 2'b01, 0);
    check("t6_nowater", int'(status), 4);
    ha = 1'b1; stock = 2'b00;
    drive(0, 0, 2'b01, 0);
    check("t6_nostock", int'(status), 5);
    stock = 2'b11;
    drive(0, 0, 2'b11, 0);
    check("t6_badsel", int'(status), 7);
    check("t6_credit_kept", int'(credit), 10);
    drive(0, 0, 2'b01, 0);
    check("t6_serve_start", int'(serve), 1);
    cycle(1);
    rst = 1'b0;
    #1;
    check("t6_rst_serve", int'(serve), 0);
    check("t6_rst_credit", int'(credit), 0);
    check("t6_rst_status", int'(status), 0);
    cycle(2);
    rst = 1'b1;
    cycle(3);

    check("change_q_empty", exp_change.size(), 0);
    check("serve_q_empty", exp_serve.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
